// File: rtl/rally_pkg.sv
// Shared types for the rally engine: FSM states, direction and player encodings.
package rally_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Horizontal direction: RIGHT moves toward increasing x.
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Vertical direction: DOWN moves toward increasing y.
  localparam logic UP    = 1'b0;
  localparam logic DOWN  = 1'b1;

  // Player identities, also used as the winner output encoding.
  localparam logic P1    = 1'b0;
  localparam logic P2    = 1'b1;

endpackage

// File: rtl/rally_tick_gen.sv
// Move-tick prescaler: divides clk by TICK_DIV and derives the slow-speed strobe.
module rally_tick_gen #(
  parameter int TICK_DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic ball_speed,
  output logic tick,
  output logic move
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       sub;

  assign tick = (cnt == CNT_LAST);
  assign move = tick && (ball_speed || (sub == 2'd3));

  // Free-running prescaler and the 2-bit divider that advances once per tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      sub <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) sub <= sub + 2'd1;
    end
  end

endmodule

// File: rtl/rally_engine.sv
// Two-player rally engine: ball motion, wall/paddle reflection, scoring and serve FSM.
module rally_engine
  import rally_pkg::*;
#(
  parameter int COORD_W     = 11,
  parameter int SCORE_W     = 5,
  parameter int X_MIN       = 15,
  parameter int X_MAX       = 625,
  parameter int Y_MIN       = 30,
  parameter int Y_MAX       = 450,
  parameter int P1_X        = 45,
  parameter int P2_X        = 595,
  parameter int TICK_DIV    = 65536,
  parameter int SERVE_DELAY = 64,
  parameter int WIN_SCORE   = 11,
  parameter int BAT_SMALL   = 15,
  parameter int BAT_LARGE   = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] p1_in,
  input  logic [COORD_W-1:0] p2_in,
  input  logic               ball_speed,
  input  logic               serve_type,
  input  logic               angle,
  input  logic               bat_size,
  input  logic               serve,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               serving,
  output logic               game_over,
  output logic               winner
);

  typedef logic [COORD_W:0] ext_t;

  localparam int DLY_W = (SERVE_DELAY > 2) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(SERVE_DELAY - 1);
  localparam logic [COORD_W-1:0] Y_MID    = COORD_W'((Y_MIN + Y_MAX) / 2);
  localparam logic [COORD_W-1:0] P1_HOME  = COORD_W'(P1_X + 1);
  localparam logic [COORD_W-1:0] P2_HOME  = COORD_W'(P2_X - 1);
  localparam logic [COORD_W-1:0] Y_TOP_IN = COORD_W'(Y_MIN + 1);
  localparam logic [COORD_W-1:0] Y_BOT_IN = COORD_W'(Y_MAX - 1);
  localparam logic [COORD_W-1:0] BAT_L    = COORD_W'(BAT_LARGE);
  localparam logic [COORD_W-1:0] BAT_S    = COORD_W'(BAT_SMALL);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state, next_state;
  logic               tick, move, move_en;
  logic               server, scorer, dx, dy, step_wide, serve_q;
  logic [COORD_W-1:0] bat;
  logic [DLY_W-1:0]   delay_cnt;
  logic               serve_rise, delay_done, launch;
  logic               hit1, hit2, goal_p1, goal_p2;
  ext_t               cand_x, cand_y, step_e, reach, dist1, dist2;
  logic [COORD_W-1:0] wall_y;
  logic               wall_dy;
  logic [SCORE_W-1:0] new_score;
  logic               reach_win, serving_d, game_over_d;

  rally_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .ball_speed (ball_speed),
    .tick       (tick),
    .move       (move)
  );

  // move is by construction a subset of tick; gating keeps both strobes coherent.
  assign move_en    = tick && move;
  assign serve_rise = serve && !serve_q;
  assign delay_done = (delay_cnt >= DLY_LAST);
  assign launch     = serve_type ? serve_rise : (move_en && delay_done);

  assign step_e  = step_wide ? ext_t'(2) : ext_t'(1);
  assign cand_x  = (dx == RIGHT) ? ext_t'(ball_x) + ext_t'(1) : ext_t'(ball_x) - ext_t'(1);
  assign cand_y  = (dy == DOWN) ? ext_t'(ball_y) + step_e : ext_t'(ball_y) - step_e;
  assign reach   = ext_t'(4) + ext_t'(bat);
  assign dist1   = (cand_y >= ext_t'(p1_in)) ? cand_y - ext_t'(p1_in) : ext_t'(p1_in) - cand_y;
  assign dist2   = (cand_y >= ext_t'(p2_in)) ? cand_y - ext_t'(p2_in) : ext_t'(p2_in) - cand_y;
  assign hit1    = (dx == LEFT)  && (cand_x == ext_t'(P1_X)) && (dist1 <= reach);
  assign hit2    = (dx == RIGHT) && (cand_x == ext_t'(P2_X)) && (dist2 <= reach);
  assign goal_p2 = !hit1 && !hit2 && (cand_x <= ext_t'(X_MIN));
  assign goal_p1 = !hit1 && !hit2 && !goal_p2 && (cand_x >= ext_t'(X_MAX));

  assign new_score = ((scorer == P1) ? p1_score : p2_score) + SCORE_W'(1);
  assign reach_win = (new_score == WIN);

  // Wall reflection applied to the candidate y, independent of paddles and goals.
  always_comb begin
    wall_y  = cand_y[COORD_W-1:0];
    wall_dy = dy;
    if (cand_y <= ext_t'(Y_MIN)) begin
      wall_y  = Y_TOP_IN;
      wall_dy = DOWN;
    end else if (cand_y >= ext_t'(Y_MAX)) begin
      wall_y  = Y_BOT_IN;
      wall_dy = UP;
    end
  end

  // State register plus registered serving/game_over flags that track it exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SERVE;
      serving   <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state     <= next_state;
      serving   <= serving_d;
      game_over <= game_over_d;
    end
  end

  // Next-state logic for the serve / rally / point / match-over sequence.
  always_comb begin
    next_state = state;
    case (state)
      SERVE:   if (launch) next_state = PLAY;
      PLAY:    if (move_en && (goal_p1 || goal_p2)) next_state = POINT;
      POINT:   next_state = reach_win ? OVER : SERVE;
      OVER:    if (serve_rise) next_state = SERVE;
      default: next_state = SERVE;
    endcase
  end

  // Status flag decode from the state being entered.
  always_comb begin
    serving_d   = (next_state == SERVE);
    game_over_d = (next_state == OVER);
  end

  // Edge register for the level-sensitive serve request.
  always_ff @(posedge clk) begin
    if (!rst) serve_q <= 1'b0;
    else      serve_q <= serve;
  end

  // Ball, score, server and rally-latch datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ball_x    <= P1_HOME;
      ball_y    <= Y_MID;
      dx        <= RIGHT;
      dy        <= DOWN;
      server    <= P1;
      scorer    <= P1;
      winner    <= P1;
      p1_score  <= '0;
      p2_score  <= '0;
      bat       <= BAT_L;
      step_wide <= 1'b0;
      delay_cnt <= '0;
    end else begin
      case (state)
        SERVE: begin
          ball_x <= (server == P1) ? P1_HOME : P2_HOME;
          ball_y <= Y_MID;
          dx     <= (server == P1) ? RIGHT : LEFT;
          dy     <= DOWN;
          if (launch) begin
            delay_cnt <= '0;
            step_wide <= angle;
            bat       <= bat_size ? BAT_S : BAT_L;
          end else if (move_en && !delay_done) begin
            delay_cnt <= delay_cnt + DLY_W'(1);
          end
        end
        PLAY: begin
          if (move_en) begin
            if (goal_p1 || goal_p2) begin
              scorer <= goal_p1 ? P1 : P2;
            end else begin
              ball_y <= wall_y;
              dy     <= wall_dy;
              if (hit1) begin
                ball_x <= P1_HOME;
                dx     <= RIGHT;
              end else if (hit2) begin
                ball_x <= P2_HOME;
                dx     <= LEFT;
              end else begin
                ball_x <= cand_x[COORD_W-1:0];
              end
            end
          end
        end
        POINT: begin
          if (scorer == P1) p1_score <= new_score;
          else              p2_score <= new_score;
          if (reach_win) begin
            winner <= scorer;
          end else begin
            server <= ~scorer;
            ball_x <= (scorer == P2) ? P1_HOME : P2_HOME;
            ball_y <= Y_MID;
            dx     <= (scorer == P2) ? RIGHT : LEFT;
            dy     <= DOWN;
          end
        end
        OVER: begin
          if (serve_rise) begin
            p1_score <= '0;
            p2_score <= '0;
            server   <= P1;
            ball_x   <= P1_HOME;
            ball_y   <= Y_MID;
            dx       <= RIGHT;
            dy       <= DOWN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rally_engine.md
# rally_engine

Parametrised two-player ball-and-paddle rally engine. It owns ball motion, wall and paddle reflection, scoring, a serve state machine and match-end detection for a rectangular field whose geometry, coordinate width, speed and win score are all set by parameters. It sits between the paddle position inputs and the video renderer and scoreboard, and is the successor of the fixed-geometry game controller.

## Interface
- COORD_W, 11, coordinate width of every x/y port
- SCORE_W, 5, score width
- X_MIN, 15, left goal line: ball x <= X_MIN scores for P2
- X_MAX, 625, right goal line: ball x >= X_MAX scores for P1
- Y_MIN, 30, top wall
- Y_MAX, 450, bottom wall
- P1_X, 45, P1 paddle column
- P2_X, 595, P2 paddle column
- TICK_DIV, 65536, clk cycles per move tick (>= 2)
- SERVE_DELAY, 64, move ticks before an auto serve
- WIN_SCORE, 11, score that ends the match (< 2^SCORE_W)
- BAT_SMALL, 15, extra paddle half-height when bat_size=1
- BAT_LARGE, 25, extra paddle half-height when bat_size=0
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- p1_in, p2_in  in  COORD_W  paddle centre y
- ball_speed  in  1  0 = slow (move every 4th tick), 1 = fast (move every tick)
- serve_type  in  1  0 = auto, 1 = manual
- angle  in  1  0 = narrow (|dy| = 1), 1 = wide (|dy| = 2)
- bat_size  in  1  0 = large, 1 = small
- serve  in  1  manual serve / match restart request (level; rising edge is used)
- p1_score, p2_score  out  SCORE_W
- ball_x, ball_y  out  COORD_W
- serving  out  1  high in SERVE
- game_over  out  1  high in OVER
- winner  out  1  0 = P1, 1 = P2; valid while game_over=1

## Operation
- Tick: counter 0..TICK_DIV-1 wraps. `tick` is asserted in the cycle where the counter equals TICK_DIV-1. A 2-bit sub-counter advances on every tick. `move` = tick && (ball_speed || sub==3).
- States: SERVE, PLAY, POINT, OVER.
- SERVE: ball parked at (server==P1 ? P1_X+1 : P2_X-1, (Y_MIN+Y_MAX)/2). dx points toward the opponent; dy = down.
  - Exit to PLAY on one of: serve_type=0 and SERVE_DELAY move ticks have elapsed; serve_type=1 and a serve rising edge is seen (edge register on serve).
  - `angle` and `bat_size` are latched on exit and held constant for the rally.
- PLAY: on each `move` cycle, compute the candidate position c = pos + (dx ? +1 : -1, dy ? +step : -step) in COORD_W+1 bits.
  - Wall: if c.y <= Y_MIN, then y = Y_MIN+1 and dy = down. If c.y >= Y_MAX, then y = Y_MAX-1 and dy = up.
  - Paddle: the hit window is |c.y - p_in| <= 4+bat, compared in COORD_W+1 bits with no underflow.
    - Moving left with c.x == P1_X and in the window: x = P1_X+1, dx = right.
    - Moving right with c.x == P2_X and in the window: x = P2_X-1, dx = left.
  - Goal: c.x <= X_MIN gives a point to P2. c.x >= X_MAX gives a point to P1. Go to POINT; the ball holds its position.
  - Precedence: paddle beats goal; wall is applied independently of both.
- POINT (1 cycle): the scorer's score is incremented.
  - If the new score == WIN_SCORE, go to OVER with winner = scorer.
  - Otherwise the server becomes the player who lost the point, and go to SERVE.
- OVER: all state is frozen. A serve rising edge clears both scores, sets server = P1 and goes to SERVE. serve_type is ignored in OVER.
- Scores never exceed WIN_SCORE.
- Reset (rst=0 at an edge):
  - State SERVE, server P1.
  - Scores 0; counters 0; serve-delay count 0.
  - Ball at (P1_X+1, (Y_MIN+Y_MAX)/2), dx right, dy down.
  - Latched bat = BAT_LARGE, step = 1; edge register 0.
  - Outputs: serving=1, game_over=0, winner=0.
  - Reset asserted mid-rally or mid-match aborts it.

## Timing
- All outputs are registered.
- Position update is visible 1 cycle after a move cycle.
- Goal detection on move cycle N: state=POINT at N+1; score updated at N+2; serving or game_over at N+2.
- Manual serve: rising edge sampled at cycle N; PLAY at N+1; first motion on the next `move` cycle.
- Auto serve: PLAY on the edge after the SERVE_DELAY-th move tick counted in SERVE.
- Paddle inputs are sampled only on move cycles, with no input latency.

## Structure
- Package rally_pkg holds:
  - the state enum (SERVE, PLAY, POINT, OVER);
  - the direction encodings (LEFT/RIGHT, UP/DOWN);
  - the player encodings (P1=0, P2=1).
- Sub-module rally_tick_gen: TICK_DIV prescaler plus the 2-bit slow divider. Outputs tick and move.

## Test plan
- TICK_DIV=4, fast, auto, SERVE_DELAY=2, p1_in=240 → PLAY after 2 move ticks; ball_x steps 46→47→48 every 4 cycles.
- Ball moving left at y=240, p1_in=250, bat_size=0 → reflects at x=46 with dx=right; same with p1_in=300 → P2 scores, p2_score=1, server=P1, ball parked at (46,240).
- Wide angle with ball at y=32 moving up → y=31 and dy=down; with dy=1 the same wall rule holds.
- WIN_SCORE=3, three P1 goals → p1_score=3, game_over=1, winner=0, ball frozen; serve pulse → scores 0, serving=1.
- Manual serve with serve held high through SERVE → exactly one launch per rising edge; slow mode moves once every 4 ticks.
- rst=0 mid-rally with scores 2:1 → next cycle scores 0:0, serving=1, ball at (46,240).
